// File: rtl/iter_muldiv_unit_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit:
// funct3 op codes, FSM state encodings and operand-signedness helpers.
package iter_muldiv_unit_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_CALC = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  // MUL only needs the low half, which is identical for any signedness.
  function automatic logic rs1_is_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/iter_muldiv_unit_step.sv
// Combinational UNROLL-deep chain of unsigned shift-add (multiply) or
// restoring shift-subtract (divide) steps on the {acc, lo} register pair.
module iter_muldiv_unit_step #(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Multiply: lo holds the multiplier, consumed LSB first while product bits
  // shift in from the top. Divide: lo holds the dividend, replaced by quotient bits.
  always_comb begin
    acc     = acc_i;
    lo      = lo_i;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        shifted = {acc, lo[XLEN-1]};
        diff    = shifted - {1'b0, opnd_i};
        lo      = {lo[XLEN-2:0], ~diff[XLEN]};
        acc     = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      end else begin
        sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
        lo  = {sum[0], lo[XLEN-1:1]};
        acc = sum[XLEN:1];
      end
    end
    acc_o = acc;
    lo_o  = lo;
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit: IDLE -> CALC -> DONE FSM with a
// valid/ready handshake, kill, and RISC-V divide-by-zero/overflow fast path.
module iter_muldiv_unit
  import iter_muldiv_unit_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is 1 only in IDLE, out_valid only in DONE, both straight from state flops.

  localparam int              N        = XLEN / UNROLL;
  localparam int              CW       = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(N);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, fast_res, sel_res;
  logic [XLEN-1:0] step_acc, step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;

  iter_muldiv_unit_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .lo_o   (step_lo)
  );

  always_comb begin
    s1       = rs1_is_signed(op) & rs1[XLEN-1];
    s2       = rs2_is_signed(op) & rs2[XLEN-1];
    mag1     = s1 ? -rs1 : rs1;
    mag2     = s2 ? -rs2 : rs2;
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = ((op == MDU_DIV) || (op == MDU_REM)) && (rs1 == MIN_INT) && (rs2 == '1);
    // Remainder ops have op[1] set: REM* of x/0 is x, REM of MIN/-1 is 0.
    if (div_zero) fast_res = op[1] ? rs1 : '1;
    else          fast_res = op[1] ? '0 : rs1;
  end

  // Final step output, sign fixup and result select are registered together.
  always_comb begin
    prod     = {step_acc, step_lo};
    prod_fix = neg_q ? -prod : prod;
    unique case (op_q)
      MDU_MUL:                          sel_res = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  sel_res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                sel_res = neg_q ? -step_lo : step_lo;
      default:                          sel_res = rneg_q ? -step_acc : step_acc;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (kill) begin
      state_d = MDU_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (in_valid) begin
            op_d  = op;
            acc_d = '0;
            if (div_zero || div_ovf) begin
              result_d = fast_res;
              state_d  = MDU_DONE;
            end else begin
              lo_d    = op[2] ? mag1 : mag2;
              opnd_d  = op[2] ? mag2 : mag1;
              neg_d   = s1 ^ s2;
              rneg_d  = s1;
              cnt_d   = CNT_LOAD;
              state_d = MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          acc_d = step_acc;
          lo_d  = step_lo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = sel_res;
            state_d  = MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (out_ready) state_d = MDU_IDLE;
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == MDU_IDLE);
  assign out_valid = (state_q == MDU_DONE);
  assign busy      = (state_q != MDU_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Bench for iter_muldiv_unit: directed RV64M cases on an UNROLL=1 instance,
// randomized traffic on an UNROLL=4 instance against an arithmetic reference.
module tb_iter_muldiv_unit;
  import iter_muldiv_unit_pkg::*;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MAX_INT = {1'b0, {(XLEN-1){1'b1}}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // index 0: UNROLL=1 instance, index 1: UNROLL=4 instance
  logic [1:0]            in_valid, out_ready, kill;
  logic [1:0][2:0]       op;
  logic [1:0][XLEN-1:0]  rs1, rs2;
  logic [1:0]            in_ready_w, out_valid_w, busy_w;
  logic [1:0][XLEN-1:0]  result_w;

  iter_muldiv_unit #(.XLEN(XLEN), .UNROLL(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .op(op[0]), .rs1(rs1[0]), .rs2(rs2[0]), .kill(kill[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .result(result_w[0]), .busy(busy_w[0])
  );

  iter_muldiv_unit #(.XLEN(XLEN), .UNROLL(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .op(op[1]), .rs1(rs1[1]), .rs2(rs2[1]), .kill(kill[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .result(result_w[1]), .busy(busy_w[1])
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 2*XLEN arithmetic plus the RISC-V special cases.
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [2*XLEN-1:0] sa, sb, ua, ub, p;
    logic signed [XLEN-1:0]   qa, qb;
    sa = {{XLEN{a[XLEN-1]}}, a};
    sb = {{XLEN{b[XLEN-1]}}, b};
    ua = {{XLEN{1'b0}}, a};
    ub = {{XLEN{1'b0}}, b};
    qa = a;
    qb = b;
    p  = '0;
    case (f)
      MDU_MUL:    begin p = sa * sb; return p[XLEN-1:0]; end
      MDU_MULH:   begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
      MDU_MULHSU: begin p = sa * ub; return p[2*XLEN-1:XLEN]; end
      MDU_MULHU:  begin p = ua * ub; return p[2*XLEN-1:XLEN]; end
      MDU_DIV: begin
        if (b == '0) return '1;
        if (a == MIN_INT && b == '1) return a;
        return qa / qb;
      end
      MDU_DIVU: return (b == '0) ? '1 : a / b;
      MDU_REM: begin
        if (b == '0) return a;
        if (a == MIN_INT && b == '1) return '0;
        return qa % qb;
      end
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return f[2] && ((b == '0) || (((f == MDU_DIV) || (f == MDU_REM)) && a == MIN_INT && b == '1));
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return XLEN'(1);
      2:       return '1;
      3:       return MIN_INT;
      4:       return MAX_INT;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge with the unit idle; returns just after the accept edge.
  task automatic issue(input int idx, input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    in_valid[idx] = 1'b1;
    op[idx]       = f;
    rs1[idx]      = a;
    rs2[idx]      = b;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    rs1[idx]      = {$urandom, $urandom};
    rs2[idx]      = {$urandom, $urandom};
  endtask

  // Latency counts edges after the accept edge; fast-path results are
  // already registered by the accept edge itself, so their latency is 0.
  task automatic wait_result(input int idx, input string tag, input int exp_lat, input int hold);
    int n = 0;
    logic ir_low = 1'b1;
    logic stable = 1'b1;
    logic [XLEN-1:0] r0;
    while (!out_valid_w[idx] && n < 200) begin
      if (in_ready_w[idx]) ir_low = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, XLEN'(n), XLEN'(exp_lat));
    check({tag, " result"}, result_w[idx], exp_q.pop_front());
    if (exp_lat > 0) check({tag, " in_ready_low_in_calc"}, XLEN'(ir_low), XLEN'(1));
    r0 = result_w[idx];
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!out_valid_w[idx] || in_ready_w[idx] || result_w[idx] !== r0) stable = 1'b0;
    end
    if (hold > 0) check({tag, " stall_stable"}, XLEN'(stable), XLEN'(1));
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    check({tag, " out_valid_drop"}, XLEN'(out_valid_w[idx]), XLEN'(0));
    check({tag, " in_ready_back"}, XLEN'(in_ready_w[idx]), XLEN'(1));
  endtask

  task automatic run_directed(input string tag, input logic [2:0] f, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
    exp_q.push_back(exp);
    issue(0, f, a, b);
    wait_result(0, tag, lat, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [2:0] f;
    logic [XLEN-1:0] a, b;
    logic seen;
    nrst = 1'b0;
    in_valid = '0; out_ready = '0; kill = '0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset out_valid", XLEN'(out_valid_w[i]), XLEN'(0));
      check("reset busy", XLEN'(busy_w[i]), XLEN'(0));
      check("reset result", result_w[i], '0);
      check("reset in_ready", XLEN'(in_ready_w[i]), XLEN'(1));
    end
    nrst = 1'b1;
    @(posedge clk); #1;

    run_directed("mul 7*-3", MDU_MUL, XLEN'(7), -XLEN'(3), 64'hFFFF_FFFF_FFFF_FFEB, 64);
    run_directed("mulh -1*-1", MDU_MULH, '1, '1, '0, 64);
    run_directed("mulhu max*max", MDU_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    run_directed("mulhsu -1*2", MDU_MULHSU, '1, XLEN'(2), '1, 64);
    run_directed("div -7/2", MDU_DIV, -XLEN'(7), XLEN'(2), 64'hFFFF_FFFF_FFFF_FFFD, 64);
    run_directed("rem -7/2", MDU_REM, -XLEN'(7), XLEN'(2), '1, 64);
    run_directed("divu 100/7", MDU_DIVU, XLEN'(100), XLEN'(7), XLEN'(14), 64);
    run_directed("remu 100/7", MDU_REMU, XLEN'(100), XLEN'(7), XLEN'(2), 64);
    run_directed("divu 5/0", MDU_DIVU, XLEN'(5), '0, '1, 0);
    run_directed("rem 5/0", MDU_REM, XLEN'(5), '0, XLEN'(5), 0);
    run_directed("div min/-1", MDU_DIV, MIN_INT, '1, MIN_INT, 0);
    run_directed("rem min/-1", MDU_REM, MIN_INT, '1, '0, 0);

    // Consumer stall in DONE for 10 cycles.
    exp_q.push_back(XLEN'(15));
    issue(0, MDU_MUL, XLEN'(3), XLEN'(5));
    wait_result(0, "stall mul 3*5", 64, 10);

    // Kill in the middle of CALC: result must never appear.
    issue(0, MDU_MUL, XLEN'(7), XLEN'(9));
    repeat (19) @(posedge clk);
    #1;
    kill[0] = 1'b1;
    @(posedge clk); #1;
    kill[0] = 1'b0;
    check("kill busy", XLEN'(busy_w[0]), XLEN'(0));
    check("kill in_ready", XLEN'(in_ready_w[0]), XLEN'(1));
    seen = 1'b0;
    for (int k = 0; k < 70; k++) begin
      if (out_valid_w[0]) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("kill no out_valid", XLEN'(seen), XLEN'(0));

    // Kill together with in_valid in IDLE: request must be refused.
    in_valid[0] = 1'b1; kill[0] = 1'b1; op[0] = MDU_MUL; rs1[0] = XLEN'(2); rs2[0] = XLEN'(2);
    @(posedge clk); #1;
    in_valid[0] = 1'b0; kill[0] = 1'b0;
    check("kill+in_valid busy", XLEN'(busy_w[0]), XLEN'(0));

    // Asynchronous reset mid-CALC: outputs return to reset values before the next edge.
    issue(0, MDU_MUL, XLEN'(7), XLEN'(9));
    repeat (10) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("async rst busy", XLEN'(busy_w[0]), XLEN'(0));
    check("async rst out_valid", XLEN'(out_valid_w[0]), XLEN'(0));
    check("async rst in_ready", XLEN'(in_ready_w[0]), XLEN'(1));
    check("async rst result", result_w[0], '0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic on the UNROLL=4 instance.
    for (int i = 0; i < 3000; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp_q.push_back(ref_model(f, a, b));
      issue(1, f, a, b);
      wait_result(1, $sformatf("rand op%0d a=%h b=%h", f, a, b), is_fast(f, a, b) ? 0 : 16, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
